// File: rtl/alu_pkg.sv
// Shared constants, instruction field layout and FSM state type for the ALU issue controller.
package alu_pkg;

    localparam int unsigned DATA_W = 20;
    localparam int unsigned NREGS  = 8;
    localparam int unsigned IMM_W  = 7;
    localparam int unsigned INSTR_W = 20;

    localparam int unsigned OP_LSB     = 17;
    localparam int unsigned IMM_SEL_BIT = 16;
    localparam int unsigned RD_LSB     = 13;
    localparam int unsigned RS1_LSB    = 10;
    localparam int unsigned RS2_LSB    = 7;
    localparam int unsigned IMM_LSB    = 0;

    localparam logic [2:0] OP_0 = 3'd0;
    localparam logic [2:0] OP_1 = 3'd1;
    localparam logic [2:0] OP_2 = 3'd2;
    localparam logic [2:0] OP_3 = 3'd3;
    localparam logic [2:0] OP_4 = 3'd4;
    localparam logic [2:0] OP_5 = 3'd5;
    localparam logic [2:0] OP_6 = 3'd6;
    localparam logic [2:0] OP_7 = 3'd7;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        EXEC   = 2'd2,
        WB     = 2'd3
    } state_t;

endpackage

// File: rtl/alu_regfile.sv
// 8-entry register file: two async operand reads, async debug read, one sync write, r0 fixed at 0.
module alu_regfile
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [2:0]        waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [2:0]        raddr_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic [2:0]        raddr_b,
    output logic [DATA_W-1:0] rdata_b,
    input  logic [2:0]        dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    logic [DATA_W-1:0] regs [NREGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (waddr != 3'd0)) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata_a  = regs[raddr_a];
    assign rdata_b  = regs[raddr_b];
    assign dbg_data = regs[dbg_addr];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue/writeback controller wrapped around a combinational ALU: decode, operand fetch,
// result capture and register writeback, one instruction every four cycles.
module alu_issue_ctrl
    import alu_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               instr_valid,
    output logic               instr_ready,
    input  logic [INSTR_W-1:0] instr,
    input  logic               load_en,
    input  logic [2:0]         load_addr,
    input  logic [DATA_W-1:0]  load_data,
    output logic [DATA_W-1:0]  alu_in1,
    output logic [DATA_W-1:0]  alu_in2,
    output logic [2:0]         alu_op,
    input  logic [DATA_W-1:0]  alu_result,
    input  logic               alu_eq,
    output logic               wb_valid,
    output logic [2:0]         wb_rd,
    output logic [DATA_W-1:0]  wb_data,
    output logic               eq_flag,
    input  logic [2:0]         dbg_addr,
    output logic [DATA_W-1:0]  dbg_data
);

    state_t state_q, state_d;
    logic [INSTR_W-1:0] instr_q;

    logic [2:0]        rd, rs1, rs2;
    logic              imm_sel;
    logic [DATA_W-1:0] imm_ext;
    logic [DATA_W-1:0] rdata_a, rdata_b;
    logic [DATA_W-1:0] op_b;
    logic              accept;

    logic              rf_we;
    logic [2:0]        rf_waddr;
    logic [DATA_W-1:0] rf_wdata;

    assign rd      = instr_q[RD_LSB +: 3];
    assign rs1     = instr_q[RS1_LSB +: 3];
    assign rs2     = instr_q[RS2_LSB +: 3];
    assign imm_sel = instr_q[IMM_SEL_BIT];
    assign imm_ext = {{(DATA_W - IMM_W){1'b0}}, instr_q[IMM_LSB +: IMM_W]};
    assign op_b    = imm_sel ? imm_ext : rdata_b;

    assign instr_ready = (state_q == IDLE);
    assign accept      = instr_valid && instr_ready;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = DECODE;
            DECODE:  state_d = EXEC;
            EXEC:    state_d = WB;
            WB:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Loads and writebacks never compete: loads are only honoured in IDLE, writeback only in WB.
    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = '0;
        rf_wdata = '0;
        if (state_q == IDLE && load_en) begin
            rf_we    = 1'b1;
            rf_waddr = load_addr;
            rf_wdata = load_data;
        end else if (state_q == WB) begin
            rf_we    = 1'b1;
            rf_waddr = rd;
            rf_wdata = wb_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                instr_q <= instr;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_in1 <= '0;
            alu_in2 <= '0;
            alu_op  <= OP_0;
        end else if (state_q == DECODE) begin
            alu_in1 <= rdata_a;
            alu_in2 <= op_b;
            alu_op  <= instr_q[OP_LSB +: 3];
        end
    end

    // wb_data doubles as the captured ALU result that gets written back during WB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid <= 1'b0;
            wb_rd    <= '0;
            wb_data  <= '0;
            eq_flag  <= 1'b0;
        end else begin
            wb_valid <= (state_q == EXEC);
            if (state_q == EXEC) begin
                wb_rd   <= rd;
                wb_data <= alu_result;
                eq_flag <= alu_eq;
            end
        end
    end

    alu_regfile u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (rf_we),
        .waddr    (rf_waddr),
        .wdata    (rf_wdata),
        .raddr_a  (rs1),
        .rdata_a  (rdata_a),
        .raddr_b  (rs2),
        .rdata_b  (rdata_b),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

endmodule
